ll8_to_fifo36: RTL and testbench



---
 rtl/ll8_to_fifo36_pkg.sv | 32 +++
 rtl/ll8_to_fifo36.sv | 86 ++++++++
 tb/tb_ll8_to_fifo36.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ll8_to_fifo36_pkg.sv
// rtl/ll8_to_fifo36_pkg.sv - shared fifo36 word layout and packer state encodings
//
// Purpose: constants common to the fifo36 family and the RX realign stage.
//   36-bit word layout: {occ[1:0], eof, sof, data[31:0]}
//   SOF_BIT / EOF_BIT / OCC_LSB : bit positions inside the 36-bit word
//   OCC_FULL                    : occ value of a word carrying all 4 bytes
//   f36_state_e                 : byte packer states (value = bytes held, FULL aside)
// Ports: none (package).

package ll8_to_fifo36_pkg;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_LSB = 34;

  localparam logic [1:0] OCC_FULL = 2'd0;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_FILL1 = 3'd1,
    ST_FILL2 = 3'd2,
    ST_FILL3 = 3'd3,
    ST_FULL  = 3'd4
  } f36_state_e;

  // Big-endian lane placement: lane 0 -> [31:24] ... lane 3 -> [7:0].
  // 8*(3-lane) equals {~lane, 3'b000} for a 2-bit lane.
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    return {~lane, 3'b000};
  endfunction

endpackage

// File: rtl/ll8_to_fifo36.sv
// rtl/ll8_to_fifo36.sv - packs an 8-bit LocalLink byte stream into 36-bit fifo words
//
// Purpose: one-word-deep packer, 1 byte/clk sustained with a ready downstream.
// Ports:
//   clk, reset, clear      : clock, sync active-high reset and soft clear
//   ll_data/sof/eof/error  : receive byte and framing (error ends the frame)
//   ll_src_rdy / ll_dst_rdy: byte handshake
//   f36_data               : {occ[1:0], eof, sof, data[31:0]}
//   f36_src_rdy_o / f36_dst_rdy_i : word handshake

module ll8_to_fifo36
  import ll8_to_fifo36_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  ll_data,
  input  logic        ll_sof,
  input  logic        ll_eof,
  input  logic        ll_error,
  input  logic        ll_src_rdy,
  output logic        ll_dst_rdy,
  output logic [35:0] f36_data,
  output logic        f36_src_rdy_o,
  input  logic        f36_dst_rdy_i
);

  f36_state_e  state_q;
  logic [31:0] data_q;
  logic        sof_q;
  logic        eof_q;
  logic [1:0]  occ_q;

  logic       byte_xfer;
  logic       word_xfer;
  logic       last_byte;
  logic [1:0] lane;

  assign ll_dst_rdy    = ~(reset | clear) & ((state_q != ST_FULL) | f36_dst_rdy_i);
  assign f36_src_rdy_o = (state_q == ST_FULL);
  assign f36_data      = {occ_q, eof_q, sof_q, data_q};

  assign byte_xfer = ll_src_rdy & ll_dst_rdy;
  assign word_xfer = f36_src_rdy_o & f36_dst_rdy_i;
  assign last_byte = ll_eof | ll_error;

  // A byte accepted in FULL can only arrive alongside the word transfer,
  // so it always opens the next word at lane 0 (pass-through path).
  assign lane = (state_q == ST_FULL) ? 2'd0 : state_q[1:0];

  always_ff @(posedge clk) begin
    if (reset | clear) begin
      state_q <= ST_EMPTY;
      data_q  <= 32'h0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      occ_q   <= OCC_FULL;
    end else if (byte_xfer) begin
      if (lane == 2'd0) begin
        // New word: unfilled lanes read as zero, sof only sampled here.
        data_q <= {ll_data, 24'h0};
        sof_q  <= ll_sof;
      end else begin
        data_q[lane_lsb(lane) +: 8] <= ll_data;
      end

      if (last_byte || (lane == 2'd3)) begin
        state_q <= ST_FULL;
        eof_q   <= last_byte;
        // lane+1 wraps to 0 for a 4-byte last word, which is OCC_FULL.
        occ_q   <= last_byte ? (lane + 2'd1) : OCC_FULL;
      end else begin
        state_q <= f36_state_e'({1'b0, lane + 2'd1});
        eof_q   <= 1'b0;
        occ_q   <= OCC_FULL;
      end
    end else if (word_xfer) begin
      state_q <= ST_EMPTY;
      data_q  <= 32'h0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      occ_q   <= OCC_FULL;
    end
  end

endmodule

// File: tb/tb_ll8_to_fifo36.sv
// tb/tb_ll8_to_fifo36.sv - directed self-checking bench for ll8_to_fifo36

module tb_ll8_to_fifo36;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [7:0]  ll_data;
  logic        ll_sof;
  logic        ll_eof;
  logic        ll_error;
  logic        ll_src_rdy;
  logic        ll_dst_rdy;
  logic [35:0] f36_data;
  logic        f36_src_rdy_o;
  logic        f36_dst_rdy_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] bq[$];     // {error, eof, sof, data}
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          n_acc;
  int          first_acc;
  int          last_acc;

  ll8_to_fifo36 dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .ll_data       (ll_data),
    .ll_sof        (ll_sof),
    .ll_eof        (ll_eof),
    .ll_error      (ll_error),
    .ll_src_rdy    (ll_src_rdy),
    .ll_dst_rdy    (ll_dst_rdy),
    .f36_data      (f36_data),
    .f36_src_rdy_o (f36_src_rdy_o),
    .f36_dst_rdy_i (f36_dst_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // term: 0 = ends with eof, 1 = ends with error, 2 = unterminated
  task automatic add_frame(input int len, input logic [7:0] base, input int term);
    logic [31:0] w;
    logic [7:0]  b;
    logic        lastb;
    int          ln;
    w = 32'h0;
    for (int i = 0; i < len; i++) begin
      b     = base + 8'(i);
      lastb = (i == len - 1) && (term != 2);
      bq.push_back({lastb && (term == 1), lastb && (term == 0), (i == 0), b});
      ln = i % 4;
      w[31 - 8*ln -: 8] = b;
      if (ln == 3 || lastb) begin
        exp_q.push_back({lastb ? 2'(len % 4) : 2'd0, lastb, (i < 4), w});
        w = 32'h0;
      end
    end
  endtask

  // mode 0: downstream always ready; mode 1: 1010... with a 10-cycle stall
  task automatic run(input int mode, input int budget);
    int          cyc;
    logic        prev_hold;
    logic [35:0] prev_data;
    logic        exp_rdy;
    cyc = 0; prev_hold = 1'b0; prev_data = 36'h0;
    n_acc = 0; first_acc = -1; last_acc = -1;
    got_q.delete();
    while ((bq.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(posedge clk);
      #1;
      if (bq.size() > 0) begin
        {ll_error, ll_eof, ll_sof, ll_data} = bq[0];
        ll_src_rdy = 1'b1;
      end else begin
        {ll_error, ll_eof, ll_sof, ll_data} = 11'h0;
        ll_src_rdy = 1'b0;
      end
      f36_dst_rdy_i = (mode == 0) ? 1'b1 : ((cyc >= 20 && cyc < 30) ? 1'b0 : (cyc % 2 == 0));
      #1;
      if (prev_hold) begin
        check("hold_valid", f36_src_rdy_o, 1);
        check("hold_data", f36_data, prev_data);
      end
      exp_rdy = ~f36_src_rdy_o | f36_dst_rdy_i;
      check("ll_dst_rdy_rule", ll_dst_rdy, exp_rdy);
      if (ll_src_rdy && ll_dst_rdy) begin
        void'(bq.pop_front());
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
      end
      if (f36_src_rdy_o && f36_dst_rdy_i) begin
        got_q.push_back(f36_data);
        if (exp_q.size() > 0) check("word", f36_data, exp_q.pop_front());
        else check("extra_word", 36'(exp_q.size()), 36'd1);
      end
      prev_hold = f36_src_rdy_o & ~f36_dst_rdy_i;
      prev_data = f36_data;
      cyc++;
    end
    check("timeout", 36'(bq.size() + exp_q.size()), 36'd0);
    bq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    ll_src_rdy    = 1'b0;
    f36_dst_rdy_i = 1'b1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    ll_data = 8'h0; ll_sof = 1'b0; ll_eof = 1'b0; ll_error = 1'b0;
    ll_src_rdy = 1'b0; f36_dst_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_src_rdy", f36_src_rdy_o, 0);
    check("rst_data", f36_data, 36'h0);
    check("rst_ll_dst_rdy", ll_dst_rdy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post_rst_ll_dst_rdy", ll_dst_rdy, 1);
    check("post_rst_src_rdy", f36_src_rdy_o, 0);

    // 64-byte frame, full throughput
    add_frame(64, 8'h00, 0);
    run(0, 200);
    check("f64_words", 36'(got_q.size()), 36'd16);
    check("f64_first", got_q[0], 36'h1_00010203);
    check("f64_last", got_q[15], 36'h2_3C3D3E3F);
    check("f64_accepts", 36'(n_acc), 36'd64);
    check("f64_span", 36'(last_acc - first_acc + 1), 36'd64);

    // 61-byte frame
    add_frame(61, 8'h00, 0);
    run(0, 200);
    check("f61_last", got_q[15], 36'h6_3C000000);

    // 62-byte frame back to back with an 8-byte frame
    add_frame(62, 8'h00, 0);
    add_frame(8, 8'h40, 0);
    run(0, 200);
    check("f62_last", got_q[15], 36'hA_3C3D0000);
    check("f62_next_first", got_q[16], 36'h1_40414243);
    check("f62_span", 36'(last_acc - first_acc + 1), 36'd70);

    // backpressure: alternating ready plus a 10-cycle stall
    add_frame(40, 8'h50, 0);
    run(1, 400);
    check("bp_words", 36'(got_q.size()), 36'd10);
    check("bp_last", got_q[9], 36'h2_74757677);

    // error on byte 7, then a normal frame
    add_frame(8, 8'h10, 1);
    add_frame(5, 8'h20, 0);
    run(0, 100);
    check("err_w0", got_q[0], 36'h1_10111213);
    check("err_w1", got_q[1], 36'h2_14151617);
    check("err_next_first", got_q[2], 36'h1_20212223);
    check("err_next_last", got_q[3], 36'h6_24000000);

    // clear after 6 bytes: only the complete first word comes out
    add_frame(6, 8'h60, 2);
    run(0, 100);
    check("clr_pre_words", 36'(got_q.size()), 36'd1);
    clear = 1'b1;
    #1;
    check("clr_ll_dst_rdy", ll_dst_rdy, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    #1;
    check("clr_src_rdy", f36_src_rdy_o, 0);
    check("clr_ll_dst_rdy_after", ll_dst_rdy, 1);
    add_frame(9, 8'h80, 0);
    add_frame(1, 8'hAA, 0);
    run(0, 100);
    check("clr_words", 36'(got_q.size()), 36'd4);
    check("clr_next_first", got_q[0], 36'h1_80818283);
    check("clr_next_last", got_q[2], 36'h6_88000000);
    check("one_byte_frame", got_q[3], 36'h7_AA000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
